// File: rtl/mps_xintf_pkg.sv
`timescale 1ns/1ps
// mps_xintf_pkg
// Shared definitions for the MPS Core XINTF DPBRAM blocks: default bus
// widths and the state encodings of the TX (Zynq->DSP) and RX (DSP->Zynq)
// mirror state machines.
package mps_xintf_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [2:0] {
    W_IDLE,
    W_SNAP,
    W_WRITE,
    W_HS,
    W_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_READ,
    R_COMMIT
  } rx_state_t;

endpackage

// File: rtl/xintf_rd_pipe.sv
`timescale 1ns/1ps
// xintf_rd_pipe
// LAT-deep delay line carrying {valid, index} alongside a DPBRAM read so
// that the returning data word can be written into its shadow slot.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid, in_idx   read issued this cycle and its word index
//   out_valid, out_idx same pair delayed by LAT clocks
module xintf_rd_pipe #(
  parameter int LAT   = 1,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [LAT-1:0]   valid_sr;
  logic [IDX_W-1:0] idx_sr [LAT];

  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    logic             v_in;
    logic [IDX_W-1:0] i_in;

    if (gi == 0) begin : g_head
      assign v_in = in_valid;
      assign i_in = in_idx;
    end else begin : g_tail
      assign v_in = valid_sr[gi-1];
      assign i_in = idx_sr[gi-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_sr[gi] <= 1'b0;
        idx_sr[gi]   <= '0;
      end else begin
        valid_sr[gi] <= v_in;
        idx_sr[gi]   <= i_in;
      end
    end
  end

  assign out_valid = valid_sr[LAT-1];
  assign out_idx   = idx_sr[LAT-1];

endmodule

// File: rtl/xintf_dpbram_mirror.sv
`timescale 1ns/1ps
// xintf_dpbram_mirror
// Table-driven Zynq<->DSP XINTF DPBRAM mirror engine.
//   TX: snapshot i_tx_data, stream N_TX words to the Z->D DPBRAM from
//       TX_BASE, then hold o_w_valid until the DSP answers with i_w_ready.
//   RX: wait for i_r_valid, burst-read N_RX words from RX_BASE into a
//       shadow buffer, then commit the whole buffer to o_rx_data at once.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-low reset
//   i_enable                     run TX/RX passes continuously
//   i_tx_data, o_tx_snap         TX parameter vector, latch pulse
//   o_z_to_d_addr/din/ce         Z->D DPBRAM write port
//   o_w_valid, i_w_ready         TX block handshake
//   i_r_valid                    DSP has published the RX block
//   i_d_to_z_dout, o_d_to_z_addr/ce  D->Z DPBRAM read port
//   o_rx_data, o_rx_update       committed RX words, commit pulse
//   o_tx_cnt, o_rx_cnt           completed pass counters (wrapping)
module xintf_dpbram_mirror
  import mps_xintf_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int N_TX    = 40,
  parameter int TX_BASE = 8,
  parameter int N_RX    = 48,
  parameter int RX_BASE = 128,
  parameter int RD_LAT  = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic [N_TX*DATA_W-1:0] i_tx_data,
  output logic                   o_tx_snap,
  output logic [ADDR_W-1:0]      o_z_to_d_addr,
  output logic [DATA_W-1:0]      o_z_to_d_din,
  output logic                   o_z_to_d_ce,
  output logic                   o_w_valid,
  input  logic                   i_w_ready,
  input  logic                   i_r_valid,
  input  logic [DATA_W-1:0]      i_d_to_z_dout,
  output logic [ADDR_W-1:0]      o_d_to_z_addr,
  output logic                   o_d_to_z_ce,
  output logic [N_RX*DATA_W-1:0] o_rx_data,
  output logic                   o_rx_update,
  output logic [15:0]            o_tx_cnt,
  output logic [15:0]            o_rx_cnt
);

  localparam int TX_IDX_W = $clog2(N_TX + 1);
  localparam int RX_IDX_W = $clog2(N_RX + RD_LAT + 1);
  localparam logic [TX_IDX_W-1:0] TX_LAST       = TX_IDX_W'(N_TX - 1);
  localparam logic [RX_IDX_W-1:0] RX_LAST_ISSUE = RX_IDX_W'(N_RX - 1);
  localparam logic [RX_IDX_W-1:0] RX_LAST       = RX_IDX_W'(N_RX + RD_LAT - 1);
  localparam logic [ADDR_W-1:0]   TX_BASE_A     = ADDR_W'(TX_BASE);
  localparam logic [ADDR_W-1:0]   RX_BASE_A     = ADDR_W'(RX_BASE);

  // Window bounds: address arithmetic is ADDR_W bits and must never wrap.
  if (N_TX < 1 || TX_BASE + N_TX > (1 << ADDR_W)) begin : g_bad_tx
    $error("xintf_dpbram_mirror: TX window out of DPBRAM range");
  end
  if (N_RX < 1 || RX_BASE + N_RX > (1 << ADDR_W)) begin : g_bad_rx
    $error("xintf_dpbram_mirror: RX window out of DPBRAM range");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("xintf_dpbram_mirror: RD_LAT must be 1..4");
  end

  // ---------------- TX path ----------------
  tx_state_t             tx_state_reg;
  logic [TX_IDX_W-1:0]   tx_idx_reg;
  logic [TX_IDX_W-1:0]   tx_idx_next;
  logic [DATA_W-1:0]     snap_mem [N_TX];
  logic [15:0]           tx_cnt_reg;

  assign tx_idx_next = tx_idx_reg + 1'b1;
  assign o_tx_cnt    = tx_cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tx_state_reg  <= W_IDLE;
      tx_idx_reg    <= '0;
      tx_cnt_reg    <= '0;
      o_tx_snap     <= 1'b0;
      o_z_to_d_addr <= '0;
      o_z_to_d_din  <= '0;
      o_z_to_d_ce   <= 1'b0;
      o_w_valid     <= 1'b0;
      for (int k = 0; k < N_TX; k++) snap_mem[k] <= '0;
    end else begin
      case (tx_state_reg)
        W_IDLE: begin
          if (i_enable) begin
            o_tx_snap    <= 1'b1;
            tx_state_reg <= W_SNAP;
          end
        end
        W_SNAP: begin
          // Word 0 comes straight from the input so the first write
          // lands on the cycle right after the snapshot.
          for (int k = 0; k < N_TX; k++) snap_mem[k] <= i_tx_data[k*DATA_W +: DATA_W];
          o_tx_snap     <= 1'b0;
          o_z_to_d_ce   <= 1'b1;
          o_z_to_d_addr <= TX_BASE_A;
          o_z_to_d_din  <= i_tx_data[DATA_W-1:0];
          tx_idx_reg    <= '0;
          tx_state_reg  <= W_WRITE;
        end
        W_WRITE: begin
          if (tx_idx_reg == TX_LAST) begin
            o_z_to_d_ce   <= 1'b0;
            o_z_to_d_addr <= '0;
            o_w_valid     <= 1'b1;
            tx_state_reg  <= W_HS;
          end else begin
            tx_idx_reg    <= tx_idx_next;
            o_z_to_d_addr <= TX_BASE_A + ADDR_W'(tx_idx_next);
            o_z_to_d_din  <= snap_mem[tx_idx_next];
          end
        end
        W_HS: begin
          if (i_w_ready) begin
            o_w_valid    <= 1'b0;
            tx_cnt_reg   <= tx_cnt_reg + 16'd1;
            tx_state_reg <= W_DONE;
          end
        end
        default: tx_state_reg <= W_IDLE;   // W_DONE
      endcase
    end
  end

  // ---------------- RX path ----------------
  rx_state_t             rx_state_reg;
  logic [RX_IDX_W-1:0]   rx_idx_reg;
  logic [DATA_W-1:0]     shadow_mem [N_RX];
  logic                  rd_issue;
  logic                  pipe_valid;
  logic [RX_IDX_W-1:0]   pipe_idx;

  // Only the first N_RX cycles of R_READ issue reads; the trailing RD_LAT
  // cycles just drain the DPBRAM pipeline.
  assign rd_issue = (rx_state_reg == R_READ) && (rx_idx_reg <= RX_LAST_ISSUE);

  xintf_rd_pipe #(
    .LAT   (RD_LAT),
    .IDX_W (RX_IDX_W)
  ) u_rd_pipe (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .in_valid  (rd_issue),
    .in_idx    (rx_idx_reg),
    .out_valid (pipe_valid),
    .out_idx   (pipe_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < N_RX; k++) shadow_mem[k] <= '0;
    end else if (pipe_valid) begin
      shadow_mem[pipe_idx] <= i_d_to_z_dout;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_state_reg  <= R_IDLE;
      rx_idx_reg    <= '0;
      o_d_to_z_addr <= '0;
      o_d_to_z_ce   <= 1'b0;
      o_rx_data     <= '0;
      o_rx_update   <= 1'b0;
      o_rx_cnt      <= '0;
    end else begin
      o_rx_update <= 1'b0;
      case (rx_state_reg)
        R_IDLE: begin
          if (i_enable) begin
            o_d_to_z_ce   <= 1'b1;
            o_d_to_z_addr <= RX_BASE_A;
            rx_state_reg  <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (i_r_valid) begin
            rx_idx_reg   <= '0;
            rx_state_reg <= R_READ;
          end
        end
        R_READ: begin
          rx_idx_reg <= rx_idx_reg + 1'b1;
          if (rx_idx_reg < RX_LAST_ISSUE)
            o_d_to_z_addr <= RX_BASE_A + ADDR_W'(rx_idx_reg + 1'b1);
          if (rx_idx_reg == RX_LAST) begin
            o_d_to_z_ce  <= 1'b0;
            rx_state_reg <= R_COMMIT;
          end
        end
        default: begin                      // R_COMMIT
          for (int k = 0; k < N_RX; k++) o_rx_data[k*DATA_W +: DATA_W] <= shadow_mem[k];
          o_rx_update  <= 1'b1;
          o_rx_cnt     <= o_rx_cnt + 16'd1;
          rx_state_reg <= R_IDLE;
        end
      endcase
    end
  end

endmodule
